// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
// Imported by the divider top so state encoding and counter sizing live in one place.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Iteration counter must hold LEN-1; LEN >= 2 keeps this at least one bit wide.
  function automatic int cnt_width(input int len);
    return $clog2(len);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract,
// and restore when the trial goes negative.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] rem,
  input  logic           quo_msb,
  input  logic [LEN-1:0] divisor,
  output logic [LEN-1:0] rem_next,
  output logic           quo_bit
);

  logic [LEN:0] shifted;
  logic [LEN:0] trial;

  assign shifted = {rem, quo_msb};
  assign trial   = shifted - {1'b0, divisor};

  // A clear sign bit means the divisor fit; otherwise keep the shifted value.
  // When restoring, shifted < divisor, so its top bit is always zero.
  assign quo_bit  = ~trial[LEN];
  assign rem_next = quo_bit ? trial[LEN-1:0] : shifted[LEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, LEN iterations,
// start/finish handshake shared with the shift-add multiplier.
module seq_divider
  import div_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [LEN-1:0] dividend,
  input  logic [LEN-1:0] divisor,
  input  logic           start,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           finish,
  output logic           busy,
  output logic           div_by_zero
);

  localparam int CNT_W = cnt_width(LEN);

  div_state_t       state_reg;
  div_state_t       state_next;
  logic [CNT_W-1:0] counter_reg;
  logic [LEN-1:0]   divisor_reg;
  logic [LEN-1:0]   rem_reg;
  logic [LEN-1:0]   quo_reg;
  logic [LEN-1:0]   quotient_reg;
  logic [LEN-1:0]   remainder_reg;
  logic             dz_reg;

  logic [LEN-1:0]   rem_step;
  logic             quo_bit;
  logic [LEN-1:0]   quo_shift;
  logic             accept;
  logic             last_step;

  div_step #(
    .LEN (LEN)
  ) u_step (
    .rem      (rem_reg),
    .quo_msb  (quo_reg[LEN-1]),
    .divisor  (divisor_reg),
    .rem_next (rem_step),
    .quo_bit  (quo_bit)
  );

  assign quo_shift = {quo_reg[LEN-2:0], quo_bit};
  assign accept    = (state_reg == IDLE) && start;
  assign last_step = (state_reg == WORK) && (counter_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = WORK;
      WORK:    if (counter_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers: quo_reg doubles as the dividend shift source, its MSB
  // feeding the remainder while quotient bits enter at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg   <= '0;
      divisor_reg   <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (accept) begin
      counter_reg <= CNT_W'(LEN - 1);
      divisor_reg <= divisor;
      rem_reg     <= '0;
      quo_reg     <= dividend;
      dz_reg      <= (divisor == '0);
    end else if (state_reg == WORK) begin
      rem_reg     <= rem_step;
      quo_reg     <= quo_shift;
      counter_reg <= counter_reg - CNT_W'(1);
      if (last_step) begin
        quotient_reg  <= quo_shift;
        remainder_reg <= rem_step;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign finish      = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign div_by_zero = finish & dz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: scoreboard of expected results checked on finish,
// plus per-scenario latency, handshake and reset checks.
module tb_seq_divider;

  localparam int LEN = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [LEN-1:0] dividend = '0;
  logic [LEN-1:0] divisor = '0;
  logic [LEN-1:0] quotient;
  logic [LEN-1:0] remainder;
  logic           finish;
  logic           busy;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [LEN-1:0] q;
    logic [LEN-1:0] r;
    logic           dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.LEN(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dividend    (dividend),
    .divisor     (divisor),
    .start       (start),
    .quotient    (quotient),
    .remainder   (remainder),
    .finish      (finish),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer: every finish pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && finish) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_finish q=%h r=%h dz=%b with empty scoreboard", quotient, remainder, div_by_zero);
      end else begin
        mon_e = sb.pop_front();
        if ({quotient, remainder, div_by_zero} !== {mon_e.q, mon_e.r, mon_e.dz}) begin
          errors++;
          $display("FAIL result got q=%h r=%h dz=%b expected q=%h r=%h dz=%b",
                   quotient, remainder, div_by_zero, mon_e.q, mon_e.r, mon_e.dz);
        end else begin
          $display("finish cyc=%0d q=%h r=%h dz=%b ok", cyc, quotient, remainder, div_by_zero);
        end
      end
    end
    if (rst_n && div_by_zero && !finish) begin
      checks++;
      errors++;
      $display("FAIL dz_without_finish got div_by_zero=1 required 0");
    end
  end

  // Drive one start pulse from between edges; returns just after the accept edge.
  task automatic issue(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(a, b));
  endtask

  // Counts edges after the current point until finish is seen; -1 on timeout.
  task automatic wait_finish(output int n);
    n = -1;
    for (int i = 1; i <= 4 * LEN; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (finish) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_one(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    int   n;
    exp_t e;
    e = model(a, b);
    issue(a, b);
    wait_finish(n);
    checks++;
    if (n !== LEN) begin
      errors++;
      $display("FAIL latency %0d/%0d got %0d edges required %0d", a, b, n, LEN);
    end
    @(negedge clk);
    checks++;
    if ({finish, busy} !== 2'b00) begin
      errors++;
      $display("FAIL pulse_width got finish=%b busy=%b required 0 0", finish, busy);
    end
    checks++;
    if ({quotient, remainder} !== {e.q, e.r}) begin
      errors++;
      $display("FAIL hold got q=%h r=%h required q=%h r=%h", quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({quotient, remainder, finish, busy, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset got q=%h r=%h f=%b b=%b dz=%b required all 0",
               quotient, remainder, finish, busy, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_one(32'd100, 32'd7);
    run_one(32'hFFFF_FFFF, 32'd1);
    run_one(32'd5, 32'd9);
    run_one(32'h1234_5678, 32'd0);
    run_one(32'd0, 32'd3);
    for (int k = 0; k < 4; k++) begin
      run_one($urandom, $urandom_range(1, 65535));
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    issue(32'd100, 32'd7);
    n = -1;
    for (int i = 1; i <= LEN + 5; i++) begin
      @(posedge clk);
      #1;
      start = (i == 10);
      if (i == 10) begin
        dividend = 32'd50;
        divisor  = 32'd5;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold cycle %0d got busy=%b required 1", i, busy);
      end
      if (finish) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (n !== LEN) begin
      errors++;
      $display("FAIL busy_latency got %0d required %0d", n, LEN);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit saw_finish;
    issue(32'd1000, 32'd3);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({quotient, remainder, finish, busy, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_clear got q=%h r=%h f=%b b=%b dz=%b required all 0",
               quotient, remainder, finish, busy, div_by_zero);
    end
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw_finish = 1'b0;
    repeat (LEN + 8) begin
      @(negedge clk);
      if (finish || busy) saw_finish = 1'b1;
    end
    checks++;
    if (saw_finish !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_finish got activity=1 required 0");
    end
    run_one(32'd1000, 32'd3);
  endtask

  task automatic test_back_to_back();
    int n;
    int t1;
    int t2;
    dividend = 32'd81;
    divisor  = 32'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'd82;
    sb.push_back(model(32'd81, 32'd9));
    wait_finish(n);
    t1 = cyc;
    checks++;
    if (n !== LEN) begin
      errors++;
      $display("FAIL b2b_latency got %0d required %0d", n, LEN);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(32'd82, 32'd9));
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b required 1", busy);
    end
    wait_finish(n);
    t2 = cyc;
    checks++;
    if ((n < 0) || (t2 - t1 !== LEN + 2)) begin
      errors++;
      $display("FAIL b2b_period got %0d required %0d", (n < 0) ? -1 : t2 - t1, LEN + 2);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
